button_event_generator: RTL
===========================

// Module: button_event_generator
// PURPOSE
//  Sits directly downstream of the Debouncer and consumes its dataOut level. Converts the clean
//  button level into discrete events: PRESS, RELEASE, and auto-REPEAT while held. Events go to
//  the consumer (keyboard/console logic) over a valid/ready handshake with a one-entry output
//  register and a sticky overflow flag.
// PARAMETERS
//  counterWidth    26          width of the interval counter; must hold max(repeatDelay, repeatPeriod)-1
//  repeatDelay     25_000_000  cycles from PRESS to first REPEAT (>=1)
//  repeatPeriod    5_000_000   cycles between subsequent REPEATs (>=1)
// PORTS
//  clock          in   1  system clock, all logic on rising edge
//  reset          in   1  asynchronous, active-low reset
//  levelIn        in   1  debounced button level from Debouncer.dataOut (already synchronous)
//  eventValid     out  1  output register holds an unconsumed event
//  eventCode      out  2  event type, valid while eventValid=1
//  eventReady     in   1  consumer accepts the event on an edge where eventValid&eventReady
//  overflow       out  1  sticky: an event was dropped because the output register was occupied
//  clearOverflow  in   1  synchronous clear of overflow
// BEHAVIOUR
//  Reset (reset=0, async): state=WAIT_LOW, counter=0, eventValid=0, eventCode=0, overflow=0.
//  Event codes: PRESS=2'd0, RELEASE=2'd1, REPEAT=2'd2; 2'd3 reserved, never produced.
//  FSM (levelIn sampled on each rising edge; all transitions registered):
//   WAIT_LOW : levelIn=0 -> IDLE. levelIn=1 -> stay, no event (button held through reset is
//              not reported; PRESS requires a seen low).
//   IDLE     : levelIn=1 -> emit PRESS, counter=0, -> HELD.
//   HELD     : levelIn=0 -> emit RELEASE, -> IDLE. Else counter==repeatDelay-1 -> emit REPEAT,
//              counter=0, -> REPEATING. Else counter+1.
//   REPEATING: levelIn=0 -> emit RELEASE, -> IDLE. Else counter==repeatPeriod-1 -> emit REPEAT,
//              counter=0. Else counter+1.
//  Simultaneous levelIn=0 and counter expiry: RELEASE wins, no REPEAT.
//  Latency: levelIn change sampled at edge N -> eventValid=1, eventCode set after edge N.
//  First REPEAT appears repeatDelay edges after the PRESS edge; later ones every repeatPeriod.
//  Output register / handshake:
//   - eventValid&eventReady at edge: event consumed; eventValid falls unless a new event is
//     emitted on the same edge, in which case the new event is loaded (eventValid stays 1).
//   - new event while eventValid=1 and eventReady=0: new event dropped, register unchanged,
//     overflow<=1. FSM still advances (drops never stall the state machine).
//   - eventCode/eventValid stable while eventValid=1 and eventReady=0.
//  overflow: set wins over clearOverflow on the same edge; otherwise clearOverflow -> 0.
//  Counter arithmetic: unsigned counterWidth-bit, compared for equality; never wraps (reset to 0
//  on expiry or on leaving HELD/REPEATING). Counter is don't-care but held at 0 in WAIT_LOW/IDLE.
//  reset asserted mid-operation: immediate return to reset values; pending event lost.
// STRUCTURE
//  Shared package/include: event code constants (PRESS/RELEASE/REPEAT), FSM state encodings.
//  One natural sub-module: event_output_register (one-entry valid/ready holding register with
//  drop/overflow logic); FSM and interval counter stay in this module.
// TESTING  (bench params: counterWidth=3, repeatDelay=4, repeatPeriod=2; eventReady=1 unless noted)
//  1. Reset with levelIn=1, release reset, hold 10 cycles -> no event; drop to 0 then raise ->
//     exactly one PRESS one cycle after the rising sample.
//  2. Raise levelIn, hold 9 cycles, drop -> PRESS, REPEAT at +4, +6, +8 cycles, RELEASE
//     one cycle after the falling sample; eventValid each a single-cycle pulse.
//  3. Raise, drop on the edge where HELD counter==3 -> RELEASE only, no REPEAT; overflow=0.
//  4. eventReady=0, raise then drop after 2 cycles -> eventValid=1 code=PRESS held stable,
//     RELEASE dropped, overflow=1; set eventReady=1 -> PRESS consumed, eventValid=0.
//  5. overflow=1, clearOverflow=1 on the same edge a new drop occurs -> overflow stays 1;
//     next edge with clearOverflow=1 and no drop -> overflow=0.
//  6. Assert reset during REPEATING with an event pending -> all outputs 0 immediately;
//     after release with levelIn=1 -> WAIT_LOW, no spurious PRESS.

Source files
------------

// File: rtl/button_event_generator_pkg.sv
// Shared constants for the button event generator: event codes and FSM state encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package button_event_generator_pkg;

  // FSM states. WAIT_LOW exists so that a button already held at reset never produces a PRESS.
  typedef enum logic [1:0] {
    ST_WAIT_LOW  = 2'd0,
    ST_IDLE      = 2'd1,
    ST_HELD      = 2'd2,
    ST_REPEATING = 2'd3
  } state_e;

  // Event codes carried on eventCode. 2'd3 is reserved and never produced.
  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_REPEAT  = 2'd2;

endpackage

// File: rtl/button_event_generator_event_output_register.sv
// One-entry valid/ready holding register for button events, with a sticky overflow flag.
// Latency: an event offered at edge N is visible (vld_o=1) right after edge N.
// Backpressure: never stalls the producer; an event offered while the entry is full and not
//   being consumed is dropped and overflow_o is set.
// Ports: clock/reset (async, active-low); evt_vld_i/evt_code_i new event from the FSM;
//   rdy_i consumer ready; clear_ovf_i clears overflow; vld_o/code_o/overflow_o outputs.
module event_output_register (
  input  logic       clock,
  input  logic       reset,
  input  logic       evt_vld_i,
  input  logic [1:0] evt_code_i,
  input  logic       rdy_i,
  input  logic       clear_ovf_i,
  output logic       vld_o,
  output logic [1:0] code_o,
  output logic       overflow_o
);

  logic       vld_q, vld_d;
  logic [1:0] code_q, code_d;
  logic       ovf_q, ovf_d;
  logic       drop;

  // The entry is free for a new event if it is empty or is being consumed on this same edge.
  assign drop = evt_vld_i & vld_q & ~rdy_i;

  always_comb begin
    vld_d  = vld_q;
    code_d = code_q;
    ovf_d  = ovf_q;
    if (evt_vld_i && !drop) begin
      vld_d  = 1'b1;
      code_d = evt_code_i;
    end else if (vld_q && rdy_i) begin
      vld_d  = 1'b0;
    end
    // A drop on the same edge as a clear keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q  <= 1'b0;
      code_q <= 2'd0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      code_q <= code_d;
      ovf_q  <= ovf_d;
    end
  end

  assign vld_o      = vld_q;
  assign code_o     = code_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/button_event_generator.sv
// Turns a debounced button level into PRESS / RELEASE / auto-REPEAT events.
// Latency: a level change sampled at edge N produces eventValid=1 right after edge N.
// Backpressure: one-entry output register; events arriving while it is full and not being
//   consumed are dropped (overflow set), the FSM never stalls.
// Ports: clock, reset (async, active-low), levelIn (debounced level), eventValid/eventCode/
//   eventReady (event handshake), overflow (sticky drop flag), clearOverflow (sync clear).
module button_event_generator
  import button_event_generator_pkg::*;
#(
  parameter int counterWidth = 26,
  parameter int repeatDelay  = 25_000_000,
  parameter int repeatPeriod = 5_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       levelIn,
  output logic       eventValid,
  output logic [1:0] eventCode,
  input  logic       eventReady,
  output logic       overflow,
  input  logic       clearOverflow
);

  localparam logic [counterWidth-1:0] DELAY_LAST  = counterWidth'(repeatDelay - 1);
  localparam logic [counterWidth-1:0] PERIOD_LAST = counterWidth'(repeatPeriod - 1);
  localparam logic [counterWidth-1:0] CNT_ONE     = counterWidth'(1);

  state_e                  state_q, state_d;
  logic [counterWidth-1:0] cnt_q, cnt_d;
  logic                    evt_vld;
  logic [1:0]              evt_code;

  // Counter defaults to 0 so it is held at 0 outside HELD/REPEATING and cleared on exit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    evt_vld  = 1'b0;
    evt_code = EVT_PRESS;
    unique case (state_q)
      ST_WAIT_LOW: begin
        if (!levelIn) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (levelIn) begin
          evt_vld  = 1'b1;
          evt_code = EVT_PRESS;
          state_d  = ST_HELD;
        end
      end
      ST_HELD: begin
        // Release takes priority over a repeat expiring on the same edge.
        if (!levelIn) begin
          evt_vld  = 1'b1;
          evt_code = EVT_RELEASE;
          state_d  = ST_IDLE;
        end else if (cnt_q == DELAY_LAST) begin
          evt_vld  = 1'b1;
          evt_code = EVT_REPEAT;
          state_d  = ST_REPEATING;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_REPEATING: begin
        if (!levelIn) begin
          evt_vld  = 1'b1;
          evt_code = EVT_RELEASE;
          state_d  = ST_IDLE;
        end else if (cnt_q == PERIOD_LAST) begin
          evt_vld  = 1'b1;
          evt_code = EVT_REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_WAIT_LOW;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_WAIT_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  event_output_register u_out (
    .clock       (clock),
    .reset       (reset),
    .evt_vld_i   (evt_vld),
    .evt_code_i  (evt_code),
    .rdy_i       (eventReady),
    .clear_ovf_i (clearOverflow),
    .vld_o       (eventValid),
    .code_o      (eventCode),
    .overflow_o  (overflow)
  );

endmodule
